bf_lanes: RTL and testbench
===========================

// Module: bf_lanes
// PURPOSE
//  LANES-wide pipelined NTT/INTT butterfly with valid tracking, per-beat mode select
//  and a global stall. CT mode for forward NTT; GS mode for inverse NTT with
//  optional output halving; bypass mode for pass-through.
//  Sits between coefficient-buffer read ports and write-back in the polynomial engine.
// PARAMETERS
//  DATA_WIDTH  64                      operand width per lane
//  M           64'hFFFFFFFF00000001    prime modulus, odd, < 2^DATA_WIDTH
//  MUL_LAT     4                       modular-multiplier pipeline depth, >= 1
//  LANES       2                       parallel butterflies sharing mode/valid/stall
// PORTS
//  clk        in   1                   clock
//  rst_n      in   1                   async active-low reset
//  stall      in   1                   1 = freeze every pipeline register, outputs included
//  in_valid   in   1                   beat valid
//  mode       in   2                   00 CT, 01 GS, 10 bypass, 11 reserved (behaves as bypass)
//  half       in   1                   GS only: halve both results mod M
//  a_i        in   LANES*DATA_WIDTH    lane k = bits [k*W +: W]
//  b_i        in   LANES*DATA_WIDTH    second operand per lane
//  omg_i      in   LANES*DATA_WIDTH    twiddle per lane
//  out_valid  out  1                   result beat valid
//  a_o        out  LANES*DATA_WIDTH    first result per lane
//  b_o        out  LANES*DATA_WIDTH    second result per lane
// BEHAVIOUR
//  Reset: clk is the only clock; rst_n is asynchronous, active-low.
//   All registers clear asynchronously: out_valid=0, a_o=0, b_o=0.
//   In-flight beats are discarded. The first beat accepted after release emerges LAT cycles later.
//  Latency: LAT = MUL_LAT+2 non-stalled cycles, identical for all modes.
//   Result order equals input order; back-to-back beats with any mode mix run at 1 beat/cycle.
//  Pipeline, per lane:
//   S0 (1 reg) CT/bypass: register a, b unchanged.
//              GS: register s=(a+b) mod M and d=(a-b) mod M.
//   S1 (MUL_LAT regs) multiplier. CT computes b*w mod M; GS computes d*w mod M; bypass passes b.
//      The first operand rides a matching delay line.
//   S2 (output reg):
//              CT: a_o=(a+p) mod M, b_o=(a-p) mod M.
//              GS: a_o=s, b_o=p; if half, a_o=H(s), b_o=H(p).
//              bypass: a_o=a, b_o=b.
//  Arithmetic:
//   - Add/sub use a DATA_WIDTH+1 intermediate with a single conditional correction.
//   - Multiply is a full 2W product reduced mod M; it may be retimed across the MUL_LAT stages.
//   - H(x) = x>>1 for even x; (x>>1)+(M+1)/2 for odd x. (M+1)/2 is derived internally.
//   - Inputs must be < M; results are then always < M. Out-of-range inputs are don't-care.
//  Control: mode, half and in_valid are captured with the beat and travel with it.
//   A change of mode never affects beats already in flight.
//  Valid: out_valid is in_valid delayed LAT cycles.
//   Data regs load on every non-stalled cycle regardless of valid.
//   a_o/b_o are meaningful only while out_valid=1.
//  Stall: while stall=1, no register changes and in_valid/operands are ignored.
//   out_valid, a_o and b_o hold. Release resumes exactly where it stopped.
//  Reset mid-operation overrides stall.
// TESTING
//  (All cases use M=FFFFFFFF00000001, MUL_LAT=4, LANES=2.)
//  T1 CT: lane0 a=5, b=3, w=2 -> 6 cycles later out_valid=1, a_o=11, b_o=M-1.
//     Lane1 a=M-1, b=1, w=1 -> a_o=0, b_o=M-2.
//  T2 GS, half=0: a=5, b=3, w=2 -> a_o=8, b_o=4.
//     GS, half=1, same operands -> a_o=4, b_o=2.
//     GS, half=1: a=1, b=0, w=1 -> a_o=b_o=7FFFFFFF80000001.
//  T3 Stream 8 beats alternating CT/GS/bypass at 1/cycle.
//     -> 8 consecutive out_valid beats, each matching its own mode's golden model.
//  T4 Stall for 3 cycles while 4 beats are in flight.
//     -> outputs hold; after release all 4 emerge in order, none duplicated or lost.
//  T5 Assert rst_n=0 asynchronously mid-stream with stall=1.
//     -> out_valid, a_o, b_o read 0 immediately; no stale beat appears after release.
//  T6 Random 10k beats, all modes, random stall and valid gaps.
//     -> scoreboard against a bigint model; zero mismatches.

Source files
------------

// File: rtl/bf_lanes.sv
// rtl/bf_lanes.sv - LANES-wide pipelined modular butterfly (CT / GS / bypass) with valid tracking and global stall
module bf_lanes #(
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] M          = 64'hFFFFFFFF00000001,
    parameter int                    MUL_LAT    = 4,
    parameter int                    LANES      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic                        in_valid,
    input  logic [1:0]                  mode,
    input  logic                        half,
    input  logic [LANES*DATA_WIDTH-1:0] a_i,
    input  logic [LANES*DATA_WIDTH-1:0] b_i,
    input  logic [LANES*DATA_WIDTH-1:0] omg_i,
    output logic                        out_valid,
    output logic [LANES*DATA_WIDTH-1:0] a_o,
    output logic [LANES*DATA_WIDTH-1:0] b_o
);
    localparam int W   = DATA_WIDTH;
    localparam int LAT = MUL_LAT + 2;
    // (M+1)/2 without needing a W+1 bit constant; M is odd
    localparam logic [W-1:0] HALF_M = (M >> 1) + W'(1);
    localparam logic [1:0] MODE_CT = 2'b00;
    localparam logic [1:0] MODE_GS = 2'b01;

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] t;
        t = {1'b0, x} + {1'b0, y};
        if (t >= {1'b0, M})
            t = t - {1'b0, M};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] t;
        t = {1'b0, x} - {1'b0, y};
        if (t[W])
            t = t + {1'b0, M};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] half_mod(input logic [W-1:0] x);
        return x[0] ? ((x >> 1) + HALF_M) : (x >> 1);
    endfunction

    function automatic logic [W-1:0] mul_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        prod = prod % {{W{1'b0}}, M};
        return prod[W-1:0];
    endfunction

    // Control travels with the beat; index 0 is S0, index LAT-2 feeds the output stage
    logic [LAT-1:0] v_pipe;
    logic [1:0]     m_pipe [0:LAT-2];
    logic [LAT-2:0] h_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_pipe <= '0;
            h_pipe <= '0;
            for (int i = 0; i < LAT-1; i++)
                m_pipe[i] <= 2'b00;
        end else if (!stall) begin
            v_pipe <= {v_pipe[LAT-2:0], in_valid};
            h_pipe <= {h_pipe[LAT-3:0], half};
            m_pipe[0] <= mode;
            for (int i = 1; i < LAT-1; i++)
                m_pipe[i] <= m_pipe[i-1];
        end
    end

    assign out_valid = v_pipe[LAT-1];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [W-1:0] a_in, b_in, w_in;
        logic [W-1:0] s0_a, s0_b, s0_w;
        logic [W-1:0] a_pipe [0:MUL_LAT-1];
        logic [W-1:0] p_pipe [0:MUL_LAT-1];
        logic [W-1:0] a_d, p_d;
        logic [W-1:0] ao_n, bo_n, ao_q, bo_q;

        assign a_in = a_i[k*W +: W];
        assign b_in = b_i[k*W +: W];
        assign w_in = omg_i[k*W +: W];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s0_a <= '0;
                s0_b <= '0;
                s0_w <= '0;
                ao_q <= '0;
                bo_q <= '0;
                for (int j = 0; j < MUL_LAT; j++) begin
                    a_pipe[j] <= '0;
                    p_pipe[j] <= '0;
                end
            end else if (!stall) begin
                // GS folds its add/sub into S0 so the multiplier sees d directly
                s0_a <= (mode == MODE_GS) ? add_mod(a_in, b_in) : a_in;
                s0_b <= (mode == MODE_GS) ? sub_mod(a_in, b_in) : b_in;
                s0_w <= w_in;
                a_pipe[0] <= s0_a;
                p_pipe[0] <= m_pipe[0][1] ? s0_b : mul_mod(s0_b, s0_w);
                for (int j = 1; j < MUL_LAT; j++) begin
                    a_pipe[j] <= a_pipe[j-1];
                    p_pipe[j] <= p_pipe[j-1];
                end
                ao_q <= ao_n;
                bo_q <= bo_n;
            end
        end

        assign a_d = a_pipe[MUL_LAT-1];
        assign p_d = p_pipe[MUL_LAT-1];

        always_comb begin
            ao_n = a_d;
            bo_n = p_d;
            case (m_pipe[LAT-2])
                MODE_CT: begin
                    ao_n = add_mod(a_d, p_d);
                    bo_n = sub_mod(a_d, p_d);
                end
                MODE_GS: begin
                    ao_n = h_pipe[LAT-2] ? half_mod(a_d) : a_d;
                    bo_n = h_pipe[LAT-2] ? half_mod(p_d) : p_d;
                end
                default: begin
                    ao_n = a_d;
                    bo_n = p_d;
                end
            endcase
        end

        assign a_o[k*W +: W] = ao_q;
        assign b_o[k*W +: W] = bo_q;
    end

endmodule

// File: tb/tb_bf_lanes.sv
// tb/tb_bf_lanes.sv - randomized scoreboard bench for bf_lanes against a bigint-style model
module tb_bf_lanes;
    localparam int W       = 64;
    localparam int LANES   = 2;
    localparam int MUL_LAT = 4;
    localparam int LAT     = MUL_LAT + 2;
    localparam logic [63:0] M = 64'hFFFFFFFF00000001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         stall = 1'b0;
    logic         in_valid = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         half = 1'b0;
    logic [127:0] a_i = '0;
    logic [127:0] b_i = '0;
    logic [127:0] omg_i = '0;
    logic         out_valid;
    logic [127:0] a_o;
    logic [127:0] b_o;

    bf_lanes #(
        .DATA_WIDTH(W),
        .M(M),
        .MUL_LAT(MUL_LAT),
        .LANES(LANES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .in_valid(in_valid),
        .mode(mode),
        .half(half),
        .a_i(a_i),
        .b_i(b_i),
        .omg_i(omg_i),
        .out_valid(out_valid),
        .a_o(a_o),
        .b_o(b_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] ea;
        logic [127:0] eb;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           adv = 0;
    int           last_chk = -1;
    logic         pv = 1'b0;
    logic [127:0] pa = '0;
    logic [127:0] pb = '0;
    logic         have_ovr = 1'b0;
    logic [127:0] ovr_a = '0;
    logic [127:0] ovr_b = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] addm(input logic [63:0] x, input logic [63:0] y);
        logic [64:0] t;
        t = ({1'b0, x} + {1'b0, y}) % {1'b0, M};
        return t[63:0];
    endfunction

    function automatic logic [63:0] subm(input logic [63:0] x, input logic [63:0] y);
        logic [64:0] t;
        t = ({1'b0, x} + {1'b0, M} - {1'b0, y}) % {1'b0, M};
        return t[63:0];
    endfunction

    function automatic logic [63:0] mulm(input logic [63:0] x, input logic [63:0] y);
        logic [127:0] t;
        t = ({64'd0, x} * {64'd0, y}) % {64'd0, M};
        return t[63:0];
    endfunction

    // Halving mod an odd M: x/2 if even, otherwise (x+M)/2
    function automatic logic [63:0] halfm(input logic [63:0] x);
        logic [64:0] t;
        t = x[0] ? ({1'b0, x} + {1'b0, M}) : {1'b0, x};
        t = t / 65'd2;
        return t[63:0];
    endfunction

    task automatic ref_lane(input logic [1:0] md, input logic h, input logic [63:0] a,
                            input logic [63:0] b, input logic [63:0] w,
                            output logic [63:0] ra, output logic [63:0] rb);
        logic [63:0] p, s, d;
        case (md)
            2'b00: begin
                p  = mulm(b, w);
                ra = addm(a, p);
                rb = subm(a, p);
            end
            2'b01: begin
                s  = addm(a, b);
                d  = subm(a, b);
                p  = mulm(d, w);
                ra = h ? halfm(s) : s;
                rb = h ? halfm(p) : p;
            end
            default: begin
                ra = a;
                rb = b;
            end
        endcase
    endtask

    task automatic observe();
        if (adv != last_chk) begin
            last_chk = adv;
            if (sb.size() > 0 && sb[0].due == adv) begin
                check("out_valid", {127'd0, out_valid}, 128'd1);
                check("a_o", a_o, sb[0].ea);
                check("b_o", b_o, sb[0].eb);
                void'(sb.pop_front());
            end else begin
                check("out_valid_idle", {127'd0, out_valid}, 128'd0);
            end
        end else begin
            check("hold_valid", {127'd0, out_valid}, {127'd0, pv});
            check("hold_a_o", a_o, pa);
            check("hold_b_o", b_o, pb);
        end
        pv = out_valid;
        pa = a_o;
        pb = b_o;
    endtask

    task automatic cycle(input logic st, input logic v, input logic [1:0] md, input logic h,
                         input logic [127:0] a, input logic [127:0] b, input logic [127:0] w);
        exp_t e;
        logic [63:0] ra, rb;
        @(negedge clk);
        observe();
        stall = st; in_valid = v; mode = md; half = h;
        a_i = a; b_i = b; omg_i = w;
        @(posedge clk);
        if (!st) begin
            adv++;
            if (v) begin
                for (int l = 0; l < LANES; l++) begin
                    ref_lane(md, h, a[l*64 +: 64], b[l*64 +: 64], w[l*64 +: 64], ra, rb);
                    e.ea[l*64 +: 64] = ra;
                    e.eb[l*64 +: 64] = rb;
                end
                if (have_ovr) begin
                    e.ea = ovr_a;
                    e.eb = ovr_b;
                    have_ovr = 1'b0;
                end
                e.due = adv + LAT - 1;
                sb.push_back(e);
            end
        end
    endtask

    function automatic logic [63:0] rnd();
        logic [63:0] x;
        int r;
        x = {$urandom, $urandom};
        r = $urandom_range(0, 7);
        if (r == 0) x = 64'd0;
        if (r == 1) x = M - 64'd1;
        if (x >= M) x = x - M;
        return x;
    endfunction

    function automatic logic [127:0] rnd2();
        return {rnd(), rnd()};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0);
    endtask

    initial begin
        int beats;
        int cyc;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {127'd0, out_valid}, 128'd0);
        check("rst_a_o", a_o, 128'd0);
        check("rst_b_o", b_o, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1 CT directed
        have_ovr = 1'b1;
        ovr_a = {64'd0, 64'd11};
        ovr_b = {M - 64'd2, M - 64'd1};
        cycle(1'b0, 1'b1, 2'b00, 1'b0, {M - 64'd1, 64'd5}, {64'd1, 64'd3}, {64'd1, 64'd2});
        // T2 GS directed
        have_ovr = 1'b1;
        ovr_a = {64'd8, 64'd8};
        ovr_b = {64'd4, 64'd4};
        cycle(1'b0, 1'b1, 2'b01, 1'b0, {64'd5, 64'd5}, {64'd3, 64'd3}, {64'd2, 64'd2});
        have_ovr = 1'b1;
        ovr_a = {64'd4, 64'd4};
        ovr_b = {64'd2, 64'd2};
        cycle(1'b0, 1'b1, 2'b01, 1'b1, {64'd5, 64'd5}, {64'd3, 64'd3}, {64'd2, 64'd2});
        have_ovr = 1'b1;
        ovr_a = {64'h7FFFFFFF80000001, 64'h7FFFFFFF80000001};
        ovr_b = {64'h7FFFFFFF80000001, 64'h7FFFFFFF80000001};
        cycle(1'b0, 1'b1, 2'b01, 1'b1, {64'd1, 64'd1}, {64'd0, 64'd0}, {64'd1, 64'd1});
        idle(LAT + 1);

        // T3 back-to-back mode mix
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b1, 2'(i % 3), 1'($urandom_range(0, 1)), rnd2(), rnd2(), rnd2());
        idle(LAT + 1);

        // T4 stall with 4 beats in flight
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rnd2(), rnd2(), rnd2());
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b1, 2'b00, 1'b0, rnd2(), rnd2(), rnd2());
        idle(LAT + 1);

        // T5 async reset mid-stream while stalled
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 2'b00, 1'b0, rnd2(), rnd2(), rnd2());
        @(negedge clk);
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {127'd0, out_valid}, 128'd0);
        check("async_rst_a_o", a_o, 128'd0);
        check("async_rst_b_o", b_o, 128'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        pv = 1'b0; pa = '0; pb = '0;
        last_chk = adv;
        idle(LAT + 2);

        // T6 random stream
        beats = 0;
        cyc = 0;
        while (beats < 10000 && cyc < 40000) begin
            logic st, v;
            st = ($urandom_range(0, 4) == 0);
            v  = ($urandom_range(0, 3) != 0);
            cycle(st, v, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rnd2(), rnd2(), rnd2());
            if (v && !st) beats++;
            cyc++;
        end
        check("random_beats_sent", 128'(beats), 128'd10000);
        idle(LAT + 2);
        check("scoreboard_empty", 128'(sb.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
